// File: rtl/csr_avmm_pkg.sv
// Shared types for the CSR Avalon-MM master: command/response records, FSM states, address alignment.
// Struct field widths follow CSR_DW/CSR_AW; the master's width parameters default to these.
package csr_avmm_pkg;

  localparam int unsigned CSR_DW  = 32;
  localparam int unsigned CSR_AW  = 16;
  localparam int unsigned CSR_BW  = CSR_DW / 8;
  localparam int unsigned CSR_LSB = $clog2(CSR_BW);

  typedef struct packed {
    logic              write;
    logic [CSR_AW-1:0] addr;
    logic [CSR_DW-1:0] wdata;
    logic [CSR_BW-1:0] byteen;
  } cmd_t;

  typedef struct packed {
    logic [CSR_DW-1:0] data;
    logic              err;
  } resp_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  function automatic logic [CSR_AW-1:0] word_align(input logic [CSR_AW-1:0] addr);
    return addr & ~CSR_AW'((1 << CSR_LSB) - 1);
  endfunction

endpackage

// File: rtl/csr_resp_fifo.sv
// Synchronous response FIFO; the occupancy count feeds the master's read-credit check.
module csr_resp_fifo
  import csr_avmm_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  resp_t         push_data,
  input  logic          pop,
  output resp_t         head,
  output logic          empty,
  output logic [CW-1:0] count
);

  resp_t         mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: validity is tracked entirely by count_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/csr_avmm_master.sv
// Avalon-MM CSR master: valid/ready commands in, in-order buffered read responses out.
// Optional read timeout with error responses: define CSR_AVMM_MASTER_TIMEOUT_EN.
module csr_avmm_master
  import csr_avmm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = CSR_DW,
  parameter int unsigned ADDR_WIDTH     = CSR_AW,
  parameter int unsigned RESP_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_byteen,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_data,
  output logic                    resp_err,
  output logic [ADDR_WIDTH-1:0]   avm_address,
  output logic                    avm_read,
  output logic                    avm_write,
  output logic [DATA_WIDTH-1:0]   avm_writedata,
  output logic [DATA_WIDTH/8-1:0] avm_byteenable,
  input  logic                    avm_waitrequest,
  input  logic [DATA_WIDTH-1:0]   avm_readdata,
  input  logic                    avm_readdatavalid,
  output logic                    busy
);

  localparam int unsigned CW = $clog2(RESP_DEPTH) + 1;

  state_e        state_q, state_d;
  cmd_t          cmd_q, cmd_d;
  logic [CW-1:0] outst_q, outst_d;
  logic          proto_err_q, proto_err_d;

  logic          fifo_push, fifo_empty;
  resp_t         fifo_wdata, fifo_head;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credit_used;
  logic          credit_ok, accept, issue_done;
  logic          rdv_take, rdv_stray, drop_take, to_fire;

`ifdef CSR_AVMM_MASTER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [CW-1:0] drop_q, drop_d;

  // A timed-out read is retired early; its late data, if any, is swallowed via drop_q.
  always_comb begin
    drop_take = avm_readdatavalid && (drop_q != '0);
    to_fire   = (outst_q != '0) && !avm_readdatavalid && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    to_cnt_d  = (avm_readdatavalid || (outst_q == '0) || to_fire) ? '0 : to_cnt_q + TW'(1);
    drop_d    = drop_q + CW'(to_fire) - CW'(drop_take);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q <= '0;
      drop_q   <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
      drop_q   <= drop_d;
    end
  end
`else
  always_comb begin
    drop_take = 1'b0;
    to_fire   = 1'b0;
  end
`endif

  always_comb begin
    credit_used = {1'b0, outst_q} + {1'b0, fifo_count};
    credit_ok   = credit_used < (CW + 1)'(RESP_DEPTH);
    cmd_ready   = !reset && (state_q == IDLE) && (cmd_write || credit_ok);
    accept      = cmd_valid && cmd_ready;
    issue_done  = (state_q == ISSUE) && !avm_waitrequest;

    rdv_take    = avm_readdatavalid && !drop_take && (outst_q != '0);
    rdv_stray   = avm_readdatavalid && !drop_take && (outst_q == '0);
    proto_err_d = proto_err_q | rdv_stray;

    fifo_push       = rdv_take || to_fire;
    fifo_wdata.data = to_fire ? '0 : avm_readdata;
    fifo_wdata.err  = to_fire;

    outst_d = outst_q + CW'(issue_done && !cmd_q.write) - CW'(rdv_take || to_fire);

    state_d = state_q;
    cmd_d   = cmd_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = ISSUE;
          cmd_d.write  = cmd_write;
          cmd_d.addr   = word_align(cmd_addr);
          cmd_d.wdata  = cmd_wdata;
          cmd_d.byteen = cmd_write ? cmd_byteen : '1;
        end
      end
      ISSUE: begin
        if (issue_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      outst_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      outst_q     <= outst_d;
      proto_err_q <= proto_err_d;
    end
  end

  csr_resp_fifo #(
    .DEPTH(RESP_DEPTH)
  ) u_resp_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_data(fifo_wdata),
    .pop      (resp_ready),
    .head     (fifo_head),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign avm_read       = (state_q == ISSUE) && !cmd_q.write;
  assign avm_write      = (state_q == ISSUE) && cmd_q.write;
  assign avm_address    = cmd_q.addr;
  assign avm_writedata  = cmd_q.wdata;
  assign avm_byteenable = cmd_q.byteen;

  assign resp_valid = !fifo_empty;
  assign resp_data  = fifo_head.data;
  assign resp_err   = !fifo_empty && fifo_head.err;
  assign busy       = (state_q == ISSUE) || (outst_q != '0) || !fifo_empty;

  a_no_stray_readdatavalid: assert property (@(posedge clk) disable iff (reset) !proto_err_q);

endmodule

// File: tb/tb_csr_avmm_master.sv
// Self-checking bench for csr_avmm_master: directed literal checks plus a randomized run
// against a transaction-level model (command in flight, reads in flight, response queue).
module tb_csr_avmm_master;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 16;
  localparam int unsigned BW = DW / 8;
  localparam int unsigned D  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [BW-1:0] cmd_byteen = '0;
  logic          resp_valid, resp_ready = 1'b0, resp_err;
  logic [DW-1:0] resp_data;
  logic [AW-1:0] avm_address;
  logic          avm_read, avm_write;
  logic [DW-1:0] avm_writedata;
  logic [BW-1:0] avm_byteenable;
  logic          avm_waitrequest = 1'b0;
  logic [DW-1:0] avm_readdata = '0;
  logic          avm_readdatavalid = 1'b0;
  logic          busy;

  always #5 clk = ~clk;

  csr_avmm_master #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .RESP_DEPTH    (D),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_write        (cmd_write),
    .cmd_addr         (cmd_addr),
    .cmd_wdata        (cmd_wdata),
    .cmd_byteen       (cmd_byteen),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_data        (resp_data),
    .resp_err         (resp_err),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_write        (avm_write),
    .avm_writedata    (avm_writedata),
    .avm_byteenable   (avm_byteenable),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .busy             (busy)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;

  // Stimulus requested for the next cycle
  logic          r_reset = 1'b1, c_valid = 1'b0, c_write = 1'b0, r_ready = 1'b0, s_wait = 1'b0;
  logic [AW-1:0] c_addr = '0;
  logic [DW-1:0] c_wdata = '0;
  logic [BW-1:0] c_byteen = '0;

  // Slave responder: read data returned in order after a short delay
  typedef struct {
    logic [DW-1:0] d;
    int unsigned   t;
  } rd_t;
  rd_t           spend[$];
  bit            rand_data = 1'b1;
  bit            s_silent  = 1'b0;
  int unsigned   s_lat_max = 0;
  logic [DW-1:0] s_seq     = '0;

  // Transaction-level reference model
  bit            model_on = 1'b0;
  bit            m_issuing = 1'b0;
  bit            m_wr = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [BW-1:0] m_be = '0;
  int unsigned   m_inflight = 0;
  logic [DW-1:0] m_fifo[$];

  bit            last_acc = 1'b0;
  logic [DW-1:0] popped[$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    bit exp_ready;
    exp_ready = !r_reset && !m_issuing && (c_write || (m_inflight + m_fifo.size()) < D);
    chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, exp_ready});
    chk("avm_read", {31'b0, avm_read}, {31'b0, m_issuing && !m_wr});
    chk("avm_write", {31'b0, avm_write}, {31'b0, m_issuing && m_wr});
    chk("resp_valid", {31'b0, resp_valid}, {31'b0, m_fifo.size() != 0});
    chk("resp_err", {31'b0, resp_err}, '0);
    chk("busy", {31'b0, busy}, {31'b0, m_issuing || m_inflight != 0 || m_fifo.size() != 0});
    if (m_issuing) begin
      chk("avm_address", {16'b0, avm_address}, {16'b0, m_addr});
      chk("avm_byteenable", {28'b0, avm_byteenable}, {28'b0, m_be});
      if (m_wr) chk("avm_writedata", avm_writedata, m_wdata);
    end
    if (m_fifo.size() != 0) chk("resp_data", resp_data, m_fifo[0]);

    if (r_reset) begin
      m_issuing  = 1'b0;
      m_inflight = 0;
      m_fifo.delete();
    end else begin
      if (m_fifo.size() != 0 && r_ready) void'(m_fifo.pop_front());
      if (avm_readdatavalid) begin
        m_fifo.push_back(avm_readdata);
        if (m_inflight != 0) m_inflight--;
      end
      if (m_issuing && !s_wait) begin
        m_issuing = 1'b0;
        if (!m_wr) m_inflight++;
      end
      if (c_valid && exp_ready) begin
        m_issuing = 1'b1;
        m_wr      = c_write;
        m_addr    = c_addr & 16'hFFFC;
        m_wdata   = c_wdata;
        m_be      = c_write ? c_byteen : 4'hF;
      end
    end
  endtask

  task automatic slave_step();
    rd_t e;
    if (reset) begin
      spend.delete();
    end else begin
      if (avm_readdatavalid) void'(spend.pop_front());
      if (avm_read && !avm_waitrequest && !s_silent) begin
        e.d = rand_data ? DW'($urandom) : s_seq;
        if (!rand_data) s_seq = s_seq + 1;
        e.t = cyc + 1 + $urandom_range(0, s_lat_max);
        spend.push_back(e);
      end
    end
  endtask

  // One clock: drive at the falling edge, check and advance the model, then step past the rising edge.
  task automatic tick();
    @(negedge clk);
    reset           = r_reset;
    cmd_valid       = c_valid;
    cmd_write       = c_write;
    cmd_addr        = c_addr;
    cmd_wdata       = c_wdata;
    cmd_byteen      = c_byteen;
    resp_ready      = r_ready;
    avm_waitrequest = s_wait;
    if (spend.size() != 0 && spend[0].t <= cyc) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = spend[0].d;
    end else begin
      avm_readdatavalid = 1'b0;
      avm_readdata      = DW'($urandom);
    end
    #1;
    if (model_on) model_step();
    last_acc = cmd_valid && cmd_ready;
    if (!reset && resp_valid && resp_ready) popped.push_back(resp_data);
    slave_step();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned nacc;
    int unsigned n;

    tick();
    tick();
    model_on = 1'b1;
    r_reset  = 1'b0;

    chk("rst_avm_read", {31'b0, avm_read}, '0);
    chk("rst_avm_write", {31'b0, avm_write}, '0);
    chk("rst_avm_address", {16'b0, avm_address}, '0);
    chk("rst_avm_writedata", avm_writedata, '0);
    chk("rst_avm_byteenable", {28'b0, avm_byteenable}, '0);
    chk("rst_resp_valid", {31'b0, resp_valid}, '0);
    chk("rst_busy", {31'b0, busy}, '0);

    // Write held under waitrequest
    c_valid = 1'b1; c_write = 1'b1; c_addr = 16'h0008; c_wdata = 32'hA5A5_0003; c_byteen = 4'hF;
    s_wait = 1'b1;
    tick();
    c_valid = 1'b0;
    chk("wr_accept", {31'b0, last_acc}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("wr_held", {31'b0, avm_write}, 32'd1);
      chk("wr_addr", {16'b0, avm_address}, 32'h8);
      chk("wr_data", avm_writedata, 32'hA5A5_0003);
      tick();
    end
    s_wait = 1'b0;
    chk("wr_last", {31'b0, avm_write}, 32'd1);
    tick();
    chk("wr_done", {31'b0, avm_write}, '0);
    chk("wr_no_resp", {31'b0, resp_valid}, '0);
    chk("wr_idle", {31'b0, busy}, '0);

    // Single read, data two cycles after acceptance
    rand_data = 1'b0; s_seq = 32'h1234_5678; s_lat_max = 0;
    c_valid = 1'b1; c_write = 1'b0; c_addr = 16'h000C;
    tick();
    c_valid = 1'b0;
    chk("rd_avm_read", {31'b0, avm_read}, 32'd1);
    chk("rd_addr", {16'b0, avm_address}, 32'hC);
    chk("rd_byteen", {28'b0, avm_byteenable}, 32'hF);
    tick();
    tick();
    chk("rd_resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("rd_resp_data", resp_data, 32'h1234_5678);
    chk("rd_resp_err", {31'b0, resp_err}, '0);
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    chk("rd_popped_idle", {31'b0, busy}, '0);

    // Five reads against a four-entry credit
    s_seq = 32'd1; popped.delete(); nacc = 0;
    c_valid = 1'b1; c_write = 1'b0; c_addr = 16'h0010;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_acc) begin
        nacc++;
        c_addr = c_addr + 16'h4;
      end
    end
    chk("credit_accepts", nacc, 32'd4);
    chk("credit_blocked", {31'b0, cmd_ready}, '0);
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    for (int i = 0; i < 20 && nacc < 5; i++) begin
      tick();
      if (last_acc) nacc++;
    end
    c_valid = 1'b0;
    chk("credit_fifth", nacc, 32'd5);
    r_ready = 1'b1;
    for (int i = 0; i < 30 && popped.size() < 5; i++) tick();
    r_ready = 1'b0;
    chk("order_count", popped.size(), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < popped.size()) chk("order_data", popped[i], DW'(i + 1));
    end

    // Misaligned address
    c_valid = 1'b1; c_addr = 16'h000E;
    tick();
    c_valid = 1'b0;
    chk("align_addr", {16'b0, avm_address}, 32'hC);
    r_ready = 1'b1;
    for (int i = 0; i < 10 && (busy || i == 0); i++) tick();
    r_ready = 1'b0;
    chk("align_drained", {31'b0, busy}, '0);

    // Reset while a read is stalled
    s_wait = 1'b1; c_valid = 1'b1; c_addr = 16'h0040;
    tick();
    c_valid = 1'b0;
    tick();
    r_reset = 1'b1;
    tick();
    r_reset = 1'b0; s_wait = 1'b0;
    chk("rst_mid_read", {31'b0, avm_read}, '0);
    chk("rst_mid_busy", {31'b0, busy}, '0);
    chk("rst_mid_resp", {31'b0, resp_valid}, '0);
    @(negedge clk);
    reset = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; avm_waitrequest = 1'b0;
    #1;
    chk("rst_release_ready", {31'b0, cmd_ready}, 32'd1);

    // Randomized traffic: backpressured first half, free-flowing second half
    rand_data = 1'b1; s_lat_max = 5;
    for (int i = 0; i < 4000; i++) begin
      r_reset  = ($urandom_range(0, 299) == 0);
      c_valid  = ($urandom_range(0, 2) != 0);
      c_write  = ($urandom_range(0, 2) == 0);
      c_addr   = AW'($urandom);
      c_wdata  = DW'($urandom);
      c_byteen = BW'($urandom);
      r_ready  = (i < 2000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      s_wait   = ($urandom_range(0, 2) == 0);
      tick();
    end
    r_reset = 1'b0; c_valid = 1'b0; s_wait = 1'b0; r_ready = 1'b1;
    for (int i = 0; i < 50 && busy; i++) tick();
    chk("final_drain", {31'b0, busy}, '0);

`ifdef CSR_AVMM_MASTER_TIMEOUT_EN
    // Silent slave: error response, late data discarded, next read intact
    model_on = 1'b0;
    r_reset = 1'b1; r_ready = 1'b0;
    tick();
    r_reset = 1'b0;
    s_silent = 1'b1; c_valid = 1'b1; c_write = 1'b0; c_addr = 16'h0020;
    tick();
    c_valid = 1'b0;
    tick();
    n = 0;
    while (!resp_valid && n < 40) begin
      tick();
      n++;
    end
    chk("to_cycles", n, 32'd16);
    chk("to_err", {31'b0, resp_err}, 32'd1);
    chk("to_data", resp_data, '0);
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    s_silent = 1'b0;
    spend.push_back('{d: 32'h0000_DEAD, t: cyc});
    tick();
    chk("to_late_dropped", {31'b0, resp_valid}, '0);
    chk("to_late_idle", {31'b0, busy}, '0);
    rand_data = 1'b0; s_seq = 32'h5555_AAAA; s_lat_max = 0;
    c_valid = 1'b1;
    tick();
    c_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin
      tick();
      n++;
    end
    chk("to_next_data", resp_data, 32'h5555_AAAA);
    chk("to_next_err", {31'b0, resp_err}, '0);
    r_ready = 1'b1;
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/csr_avmm_master.md
Name: csr_avmm_master

Overview:
- Avalon-MM master that issues CSR reads and writes toward the CSR manager's slave port.
- Used by the on-FPGA test sequencer and by the cache controller for self-configuration, e.g. pulsing the reset CSR and polling app status.
- Converts a valid/ready command stream into waitrequest-compliant bus cycles.
- Tracks outstanding reads and returns read data through a buffered valid/ready response stream.

Parameters:
- DATA_WIDTH, 32, bus data width in bits; multiple of 8.
- ADDR_WIDTH, 16, byte address width.
- RESP_DEPTH, 4, response buffer entries; also the maximum number of in-flight reads (power of 2).
- TIMEOUT_CYCLES, 1024, read timeout in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_byteen  in  DATA_WIDTH/8  byte enables (writes)
- resp_valid  out  1  read response available
- resp_ready  in  1  consumer accepts response
- resp_data  out  DATA_WIDTH  read data
- resp_err  out  1  response is a timeout error (0 when feature absent)
- avm_address  out  ADDR_WIDTH  bus address
- avm_read  out  1  bus read
- avm_write  out  1  bus write
- avm_writedata  out  DATA_WIDTH  bus write data
- avm_byteenable  out  DATA_WIDTH/8  bus byte enables
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  DATA_WIDTH  slave read data
- avm_readdatavalid  in  1  slave read data strobe
- busy  out  1  command held or reads outstanding

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high. All state clears on the clock edge where reset=1.
- Reset values: avm_read=0, avm_write=0, avm_address=0, avm_writedata=0, avm_byteenable=0, resp_valid=0, resp_err=0, busy=0, outstanding=0, buffer empty. cmd_ready=0 while reset=1.
- FSM states: IDLE and ISSUE.
  - IDLE: cmd_ready=1 if cmd_write=1, or if outstanding+buf_count < RESP_DEPTH; otherwise cmd_ready=0.
  - On IDLE accept: register the command, drive avm_read or avm_write next cycle, go to ISSUE.
  - In ISSUE: all avm_* outputs are held stable while avm_waitrequest=1.
  - ISSUE exit: on the edge where avm_waitrequest=0, deassert avm_read/avm_write and return to IDLE. A read increments outstanding on that edge.
- Command-to-bus latency: 1 cycle; back-to-back throughput is one command every 2 cycles minimum.
- Address alignment: avm_address low log2(DATA_WIDTH/8) bits are forced to 0.
- Read byte enables: avm_byteenable is all ones for reads.
- Writes: no response; a write completes when waitrequest drops.
- Read data path:
  - avm_readdatavalid pushes avm_readdata into the response FIFO and decrements outstanding.
  - readdatavalid is never stalled; the credit rule guarantees space.
  - readdatavalid with outstanding=0 is ignored and sets a sticky protocol-error flag (visible only in simulation assertion).
- Responses are delivered in request order. resp_valid = buffer not empty; pop on resp_valid & resp_ready.
- Simultaneous events:
  - Push and pop in the same cycle keep the count unchanged.
  - Issue-completion and readdatavalid in the same cycle leave outstanding unchanged.
- Reset mid-operation: in-flight commands, outstanding reads and buffered data are discarded; the bus is idle the next cycle.
- busy = (state==ISSUE) | (outstanding!=0) | (buffer not empty).

Optional Feature:
- Macro: CSR_AVMM_MASTER_TIMEOUT_EN.
- When defined:
  - A counter runs while outstanding != 0 and resets on each readdatavalid.
  - On reaching TIMEOUT_CYCLES, push a response with resp_err=1 and resp_data=0, decrement outstanding, and increment drop_count.
  - Subsequent readdatavalid while drop_count != 0 is discarded and decrements drop_count.
- When undefined: no counter; resp_err tied to 0; reads wait indefinitely.

Decomposition:
- Shared package csr_avmm_pkg:
  - cmd_t struct (write, addr, wdata, byteen)
  - resp_t struct (data, err)
  - state_e enum (IDLE, ISSUE)
  - function word_align().
- Sub-module csr_resp_fifo: synchronous FIFO of resp_t, depth RESP_DEPTH, with count output used for credit calculation.

Test Plan:
- Write 0x8 data 0xA5A5_0003 byteen 0xF, waitrequest=1 for 3 cycles -> avm_write held 3 cycles with stable address/data; deasserts after waitrequest=0; no response.
- Read 0xC, slave returns 0x1234_5678 two cycles after acceptance -> resp_valid with resp_data=0x1234_5678, resp_err=0; busy drops after pop.
- 5 reads with resp_ready=0 and RESP_DEPTH=4 -> 4 issue; cmd_ready=0 for the 5th until one pop; order preserved: data 1,2,3,4 then 5.
- Read to address 0x0E -> avm_address=0x0C.
- Reset asserted while in ISSUE with waitrequest=1 -> avm_read=0 next cycle; outstanding=0; resp_valid=0; cmd_ready=1 the cycle after reset drops.
- With CSR_AVMM_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave silent -> error response (err=1, data=0) at cycle 16; late readdatavalid 0xDEAD is discarded; the next read returns correct data.
